twiddle_rescale: RTL

- Consumer end of the CSD twiddle-multiplier result bus.
- Accepts packed complex products of width 2*NBITS_out, scaled by 2^(NBITScoeff-2), and returns them to sample width NBITS by rounding and saturation.
- Carries a valid/ready handshake so the next butterfly stage can stall it.
- Sits between each twiddle multiplier and the following FFT stage register.

---
 rtl/twiddle_rescale.sv | 115 +++++++++++
 1 files changed

// File: rtl/twiddle_rescale.sv
`default_nettype none
// ============================================================================
// twiddle_rescale : rounds and saturates twiddle products to sample width,
// 2-stage valid/ready pipeline. Build option CONVERGENT_ROUND_EN. Rev 1.0
// ============================================================================
module twiddle_rescale #(
   parameter int NBITS      = 12,
   parameter int NBITScoeff = 11,
   parameter int NBITS_out  = NBITS + NBITScoeff + 1,
   parameter int SHIFT      = NBITScoeff - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*NBITS_out-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*NBITS-1:0]       out_data,
   output logic                     out_sat,
   output logic [15:0]              sat_count,
   input  logic                     clear_count
);
   localparam int c_RW = NBITS_out + 1 - SHIFT;
   localparam logic [NBITS_out:0] c_HALF =
      {{(NBITS_out + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
   localparam logic [NBITS-1:0] c_MAX = {1'b0, {(NBITS - 1){1'b1}}};
   localparam logic [NBITS-1:0] c_MIN = {1'b1, {(NBITS - 1){1'b0}}};

   logic        r_s1_valid;
   logic        r_s2_valid;
   logic        w_s2_en;
   logic        w_s1_load;
   logic        w_s2_take;
   logic [15:0] r_sat_count;

   // S2 takes a new word when it is empty or its word leaves this cycle
   assign w_s2_en   = !r_s2_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s2_en;
   assign w_s1_load = in_valid && in_ready;
   assign w_s2_take = w_s2_en && r_s1_valid;

   // k = 1 is the real half (upper), k = 0 the imaginary half
   for (genvar k = 0; k < 2; k++) begin : g_comp
      logic [NBITS_out-1:0] w_x;
      logic [NBITS_out:0]   w_sum;
      logic [c_RW-1:0]      w_rnd;
      logic                 w_unused_lo;
      logic [c_RW-NBITS:0]  w_top;
      logic                 w_clip;
      logic [NBITS-1:0]     w_sat;
      logic [c_RW-1:0]      r_s1_rnd;
      logic [NBITS-1:0]     r_s2_val;
      logic                 r_s2_clip;

      assign w_x         = in_data[k*NBITS_out +: NBITS_out];
      assign w_sum       = {w_x[NBITS_out-1], w_x} + c_HALF;
      assign w_unused_lo = ^w_sum[SHIFT-1:0];
`ifdef CONVERGENT_ROUND_EN
      localparam logic [c_RW-1:0] c_ONE = {{(c_RW - 1){1'b0}}, 1'b1};
      // exact tie with an odd round-up result means the floor was even
      assign w_rnd = ((w_x[SHIFT-1:0] == c_HALF[SHIFT-1:0]) && w_sum[SHIFT])
                     ? (w_sum[NBITS_out:SHIFT] - c_ONE)
                     : w_sum[NBITS_out:SHIFT];
`else
      assign w_rnd = w_sum[NBITS_out:SHIFT];
`endif

      assign w_top  = r_s1_rnd[c_RW-1:NBITS-1];
      assign w_clip = !((&w_top) || !(|w_top));
      assign w_sat  = !w_clip ? r_s1_rnd[NBITS-1:0]
                    : (r_s1_rnd[c_RW-1] ? c_MIN : c_MAX);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_s1_rnd  <= '0;
            r_s2_val  <= '0;
            r_s2_clip <= 1'b0;
         end else begin
            if (w_s1_load) r_s1_rnd <= w_rnd;
            if (w_s2_take) begin
               r_s2_val  <= w_sat;
               r_s2_clip <= w_clip;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (in_ready) r_s1_valid <= in_valid;
         if (w_s2_en)  r_s2_valid <= r_s1_valid;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sat_count <= '0;
      end else if (clear_count) begin
         r_sat_count <= '0;
      end else if (r_s2_valid && out_ready && out_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = {g_comp[1].r_s2_val, g_comp[0].r_s2_val};
   assign out_sat   = g_comp[1].r_s2_clip | g_comp[0].r_s2_clip;
   assign sat_count = r_sat_count;

endmodule
`default_nettype wire
